// File: rtl/bin2bcd_pkg.sv
// Shared types, constants and the per-digit adjust helper for the sequential
// binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Double-dabble digit correction: a digit of 5 or more would exceed 9 after the shift.
  function automatic logic [3:0] add3(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational single-digit adjust applied to each scratch digit before a shift.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = add3(digit_i);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking on the output is enabled by BIN2BCD_BLANK_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [WIDTH-1:0]    bin_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                overflow_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     bcd_s_q;
  logic [WIDTH-1:0]  bin_s_q;
  logic              ovf_s_q;
  logic              busy_q;
  logic              valid_q;
  logic [BW-1:0]     bcd_q;
  logic              ovf_q;

  logic [BW-1:0]     adj_s;
  logic [WIDTH:0]    bin_shift_s;
  logic [BW-1:0]     bcd_shift_d;
  logic [WIDTH-1:0]  bin_shift_d;
  logic [BW-1:0]     result_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .digit_i (bcd_s_q[4*g +: 4]),
      .digit_o (adj_s[4*g +: 4])
    );
  end

  assign bin_shift_s = {bin_s_q, 1'b0};
  assign bin_shift_d = bin_shift_s[WIDTH-1:0];
  assign bcd_shift_d = {adj_s[BW-2:0], bin_s_q[WIDTH-1]};

`ifdef BIN2BCD_BLANK_EN
  // Blank every digit above the most significant nonzero one; digit 0 always shows.
  always_comb begin
    logic seen;
    result_d = bcd_s_q;
    seen     = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (bcd_s_q[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end else if (!seen) begin
        result_d[4*i +: 4] = BCD_BLANK;
      end else begin
        result_d[4*i +: 4] = bcd_s_q[4*i +: 4];
      end
    end
  end
`else
  assign result_d = bcd_s_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_s_q <= '0;
      bin_s_q <= '0;
      ovf_s_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            bin_s_q <= bin_i;
            bcd_s_q <= '0;
            cnt_q   <= CW'(WIDTH);
            ovf_s_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_s_q <= bcd_shift_d;
          bin_s_q <= bin_shift_d;
          if (adj_s[BW-1]) begin
            ovf_s_q <= 1'b1;
          end
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_q   <= result_d;
          ovf_q   <= ovf_s_q;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign bcd_o      = bcd_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 14-bit/5-digit instance and an
// 8-bit/2-digit instance for the overflow cases.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_m = 1'b0;
  logic [13:0] bin_m = '0;
  logic        busy_m, valid_m, ovf_m;
  logic [19:0] bcd_m;
  logic        start_s = 1'b0;
  logic [7:0]  bin_s = '0;
  logic        busy_s, valid_s, ovf_s;
  logic [7:0]  bcd_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(14), .DIGITS(5)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_m), .bin_i(bin_m),
    .busy_o(busy_m), .valid_o(valid_m), .bcd_o(bcd_m), .overflow_o(ovf_m)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_s), .bin_i(bin_s),
    .busy_o(busy_s), .valid_o(valid_s), .bcd_o(bcd_s), .overflow_o(ovf_s)
  );

  typedef struct {
    logic        sel;
    int unsigned value;
    logic [19:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: decimal digits of (v mod 10^d), blanking leading zeros when enabled.
  function automatic logic [19:0] model_bcd(input int unsigned v, input int d);
    logic [19:0] r;
    int unsigned x;
    int digs[5];
    bit seen;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      digs[i] = int'(x % 10);
      x = x / 10;
    end
    seen = 1'b0;
    for (int i = d - 1; i >= 0; i--) begin
      if (digs[i] != 0) seen = 1'b1;
      r[4*i +: 4] = 4'(digs[i]);
`ifdef BIN2BCD_BLANK_EN
      if (!seen && i > 0) r[4*i +: 4] = 4'hF;
`endif
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int unsigned v, input int d);
    int unsigned lim;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    return (v >= lim) ? 1'b1 : 1'b0;
  endfunction

  // One conversion on the selected instance; ign_at > 0 injects a start with bin=7 at that cycle.
  task automatic convert(input logic sel, input int unsigned value, input logic [19:0] exp_bcd,
                         input logic exp_ovf, input int ign_at, input string tag);
    int lat;
    int busy_cnt;
    int width;
    logic [19:0] prev;
    bit held;
    width = sel ? 8 : 14;
    prev  = sel ? {12'd0, bcd_s} : bcd_m;
    held  = 1'b1;
    @(negedge clk);
    if (sel) begin start_s = 1'b1; bin_s = 8'(value); end
    else     begin start_m = 1'b1; bin_m = 14'(value); end
    @(posedge clk); #1;
    start_m = 1'b0; start_s = 1'b0;
    bin_m = 14'($urandom); bin_s = 8'($urandom);
    lat = 0;
    busy_cnt = (sel ? busy_s : busy_m) ? 1 : 0;
    for (int k = 1; k <= width + 6; k++) begin
      if (k == ign_at) begin
        if (sel) begin start_s = 1'b1; bin_s = 8'd7; end
        else     begin start_m = 1'b1; bin_m = 14'd7; end
      end
      @(posedge clk); #1;
      start_m = 1'b0; start_s = 1'b0;
      if (sel ? valid_s : valid_m) begin
        lat = k;
        break;
      end
      if (sel ? busy_s : busy_m) busy_cnt++;
      if ((sel ? {12'd0, bcd_s} : bcd_m) !== prev) held = 1'b0;
    end
    check({tag, " latency"}, 32'(lat), 32'(width + 1));
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(width + 1));
    check({tag, " bcd held"}, {31'd0, held}, 32'd1);
    check({tag, " bcd"}, sel ? {24'd0, bcd_s} : {12'd0, bcd_m}, {12'd0, exp_bcd});
    check({tag, " ovf"}, {31'd0, sel ? ovf_s : ovf_m}, {31'd0, exp_ovf});
    check({tag, " busy at valid"}, {31'd0, sel ? busy_s : busy_m}, 32'd0);
    @(posedge clk); #1;
    check({tag, " valid pulse"}, {31'd0, sel ? valid_s : valid_m}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    bit seen_valid;
    int unsigned r;

`ifdef BIN2BCD_BLANK_EN
    vecs.push_back('{1'b0, 0,     20'hFFFF0, 1'b0});
    vecs.push_back('{1'b0, 16383, 20'h16383, 1'b0});
    vecs.push_back('{1'b0, 9,     20'hFFFF9, 1'b0});
    vecs.push_back('{1'b0, 10,    20'hFFF10, 1'b0});
    vecs.push_back('{1'b0, 42,    20'hFFF42, 1'b0});
    vecs.push_back('{1'b0, 10000, 20'h10000, 1'b0});
`else
    vecs.push_back('{1'b0, 0,     20'h00000, 1'b0});
    vecs.push_back('{1'b0, 16383, 20'h16383, 1'b0});
    vecs.push_back('{1'b0, 9,     20'h00009, 1'b0});
    vecs.push_back('{1'b0, 10,    20'h00010, 1'b0});
    vecs.push_back('{1'b0, 42,    20'h00042, 1'b0});
    vecs.push_back('{1'b0, 10000, 20'h10000, 1'b0});
`endif
    vecs.push_back('{1'b1, 123, 20'h00023, 1'b1});
    vecs.push_back('{1'b1, 99,  20'h00099, 1'b0});
    vecs.push_back('{1'b1, 255, 20'h00055, 1'b1});

    #12;
    check("reset busy", {31'd0, busy_m}, 32'd0);
    check("reset valid", {31'd0, valid_m}, 32'd0);
    check("reset bcd", {12'd0, bcd_m}, 32'd0);
    check("reset ovf", {31'd0, ovf_m}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i])
      convert(vecs[i].sel, vecs[i].value, vecs[i].bcd, vecs[i].ovf, 0, $sformatf("vec%0d", i));

    convert(1'b0, 500, model_bcd(500, 5), 1'b0, 5, "ignored start");

    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(16383, 0);
      convert(1'b0, r, model_bcd(r, 5), model_ovf(r, 5), 0, $sformatf("rand%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(255, 0);
      convert(1'b1, r, model_bcd(r, 2), model_ovf(r, 2), 0, $sformatf("srand%0d", i));
    end

    // Back-to-back throughput: restart right after the valid cycle.
    convert(1'b0, 8191, model_bcd(8191, 5), 1'b0, 0, "b2b a");
    convert(1'b0, 1, model_bcd(1, 5), 1'b0, 0, "b2b b");

    // Asynchronous reset in the middle of a conversion.
    convert(1'b0, 9999, model_bcd(9999, 5), 1'b0, 0, "pre-abort");
    @(negedge clk); start_m = 1'b1; bin_m = 14'd1234;
    @(posedge clk); #1; start_m = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy_m}, 32'd0);
    check("abort valid", {31'd0, valid_m}, 32'd0);
    check("abort bcd", {12'd0, bcd_m}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (valid_m || busy_m) seen_valid = 1'b1;
    end
    check("no valid after abort", {31'd0, seen_valid}, 32'd0);
    convert(1'b0, 42, model_bcd(42, 5), 1'b0, 0, "after abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
